vga_sprite_overlay: RTL and testbench

//  Parametrised N-sprite overlay stage between VGA timing/palette lookup and the RGB pins.

---
 rtl/vga_sprite_overlay.sv | 140 ++++++++++++++
 tb/tb_vga_sprite_overlay.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_sprite_overlay.sv
// rtl/vga_sprite_overlay.sv - N-sprite button-driven overlay with a fixed 2-cycle compositing pipeline
module vga_sprite_overlay #(
    parameter int NUM_SPRITES    = 4,
    parameter int SPRITE_SIZE    = 50,
    parameter int STEP           = 2,
    parameter int H_RES          = 640,
    parameter int V_RES          = 480,
    parameter int INIT_X         = 100,
    parameter int INIT_Y         = 200,
    parameter int INIT_GAP       = 64,
    parameter int BITS_PER_COLOR = 12,
    parameter logic [NUM_SPRITES*BITS_PER_COLOR-1:0] SPRITE_COLORS = {NUM_SPRITES{12'h1F3}}
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [9:0]                  x,
    input  logic [8:0]                  y,
    input  logic                        active,
    input  logic                        screen_end,
    input  logic [BITS_PER_COLOR-1:0]   bg_color,
    input  logic                        btn_up,
    input  logic                        btn_down,
    input  logic                        btn_left,
    input  logic                        btn_right,
    input  logic                        btn_sel,
    output logic [BITS_PER_COLOR-1:0]   color_out,
    output logic                        hit,
    output logic [2:0]                  sel_idx,
    output logic [10*NUM_SPRITES-1:0]   pos_x_bus,
    output logic [9*NUM_SPRITES-1:0]    pos_y_bus
);
    localparam int BPC = BITS_PER_COLOR;
    localparam logic signed [11:0] X_MAX  = 12'(H_RES - SPRITE_SIZE);
    localparam logic signed [11:0] Y_MAX  = 12'(V_RES - SPRITE_SIZE);
    localparam logic signed [11:0] STEP_S = 12'(STEP);
    localparam logic [2:0]         LAST_SEL = 3'(NUM_SPRITES - 1);

    // button bit order: {sel, right, left, down, up}
    logic [4:0]             btn_s1_q, btn_s1_d, btn_s2_q, btn_s2_d;
    logic                   sel_prev_q, sel_prev_d;
    logic [2:0]             sel_q, sel_d;
    logic [9:0]             pos_x_q [NUM_SPRITES];
    logic [9:0]             pos_x_d [NUM_SPRITES];
    logic [8:0]             pos_y_q [NUM_SPRITES];
    logic [8:0]             pos_y_d [NUM_SPRITES];
    logic [NUM_SPRITES-1:0] hit_vec_q, hit_vec_d;
    logic [BPC-1:0]         bg_q, bg_d, color_q, color_d, win_color;
    logic                   act_q, act_d, hit_q, hit_d;
    logic                   sel_edge;
    logic signed [11:0]     dx, dy, nx, ny;

    always_comb begin
        btn_s1_d   = {btn_sel, btn_right, btn_left, btn_down, btn_up};
        btn_s2_d   = btn_s1_q;
        sel_prev_d = btn_s2_q[4];
        sel_edge   = btn_s2_q[4] & ~sel_prev_q;
        sel_d      = sel_q;
        if (sel_edge && NUM_SPRITES > 1)
            sel_d = (sel_q == LAST_SEL) ? 3'd0 : sel_q + 3'd1;

        // the move uses sel_q, so a same-cycle sel edge applies to the old sprite
        dx = (btn_s2_q[3] ? STEP_S : 12'sd0) - (btn_s2_q[2] ? STEP_S : 12'sd0);
        dy = (btn_s2_q[1] ? STEP_S : 12'sd0) - (btn_s2_q[0] ? STEP_S : 12'sd0);
        pos_x_d = pos_x_q;
        pos_y_d = pos_y_q;
        nx = '0;
        ny = '0;
        for (int i = 0; i < NUM_SPRITES; i++) begin
            if (screen_end && sel_q == 3'(i)) begin
                nx = $signed({2'b00, pos_x_q[i]}) + dx;
                ny = $signed({3'b000, pos_y_q[i]}) + dy;
                if (nx < 0)          pos_x_d[i] = '0;
                else if (nx > X_MAX) pos_x_d[i] = X_MAX[9:0];
                else                 pos_x_d[i] = nx[9:0];
                if (ny < 0)          pos_y_d[i] = '0;
                else if (ny > Y_MAX) pos_y_d[i] = Y_MAX[8:0];
                else                 pos_y_d[i] = ny[8:0];
            end
        end

        for (int i = 0; i < NUM_SPRITES; i++) begin
            hit_vec_d[i] = ({1'b0, x} >= {1'b0, pos_x_q[i]}) &&
                           ({1'b0, x} <= {1'b0, pos_x_q[i]} + 11'(SPRITE_SIZE - 1)) &&
                           ({1'b0, y} >= {1'b0, pos_y_q[i]}) &&
                           ({1'b0, y} <= {1'b0, pos_y_q[i]} + 10'(SPRITE_SIZE - 1));
        end
        bg_d  = bg_color;
        act_d = active;

        win_color = bg_q;
        for (int i = NUM_SPRITES - 1; i >= 0; i--) begin
            if (hit_vec_q[i]) win_color = SPRITE_COLORS[i*BPC +: BPC];
        end
        color_d = act_q ? win_color : '0;
        hit_d   = act_q & (|hit_vec_q);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            btn_s1_q   <= '0;
            btn_s2_q   <= '0;
            sel_prev_q <= 1'b0;
            sel_q      <= '0;
            for (int i = 0; i < NUM_SPRITES; i++) begin
                pos_x_q[i] <= 10'(INIT_X + i * INIT_GAP);
                pos_y_q[i] <= 9'(INIT_Y);
            end
            hit_vec_q  <= '0;
            bg_q       <= '0;
            act_q      <= 1'b0;
            color_q    <= '0;
            hit_q      <= 1'b0;
        end else begin
            btn_s1_q   <= btn_s1_d;
            btn_s2_q   <= btn_s2_d;
            sel_prev_q <= sel_prev_d;
            sel_q      <= sel_d;
            pos_x_q    <= pos_x_d;
            pos_y_q    <= pos_y_d;
            hit_vec_q  <= hit_vec_d;
            bg_q       <= bg_d;
            act_q      <= act_d;
            color_q    <= color_d;
            hit_q      <= hit_d;
        end
    end

    always_comb begin
        pos_x_bus = '0;
        pos_y_bus = '0;
        for (int i = 0; i < NUM_SPRITES; i++) begin
            pos_x_bus[i*10 +: 10] = pos_x_q[i];
            pos_y_bus[i*9 +: 9]   = pos_y_q[i];
        end
    end

    assign color_out = color_q;
    assign hit       = hit_q;
    assign sel_idx   = sel_q;
endmodule

// File: tb/tb_vga_sprite_overlay.sv
// tb/tb_vga_sprite_overlay.sv - self-checking bench for vga_sprite_overlay
module tb_vga_sprite_overlay;
    localparam int N   = 4;
    localparam int S   = 50;
    localparam int BPC = 12;
    localparam logic [N*BPC-1:0] COLORS = {12'h777, 12'h0C5, 12'hA0A, 12'h1F3};

    logic clk = 1'b0, reset = 1'b0;
    logic [9:0] x = '0;
    logic [8:0] y = '0;
    logic active = 1'b0, screen_end = 1'b0;
    logic [11:0] bg_color = '0;
    logic btn_up = 0, btn_down = 0, btn_left = 0, btn_right = 0, btn_sel = 0;
    logic [11:0] color_out;
    logic hit;
    logic [2:0] sel_idx;
    logic [10*N-1:0] pos_x_bus;
    logic [9*N-1:0] pos_y_bus;

    vga_sprite_overlay #(.NUM_SPRITES(N), .SPRITE_COLORS(COLORS)) dut (
        .clk(clk), .reset(reset), .x(x), .y(y), .active(active), .screen_end(screen_end),
        .bg_color(bg_color), .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left),
        .btn_right(btn_right), .btn_sel(btn_sel), .color_out(color_out), .hit(hit),
        .sel_idx(sel_idx), .pos_x_bus(pos_x_bus), .pos_y_bus(pos_y_bus)
    );

    always #20 clk = ~clk;

    int n_cmp = 0, n_bad = 0;
    int mx [N];
    int my [N];
    int msel;
    logic [4:0] h1, h2, h3;
    logic [11:0] pend_c, out_c;
    logic pend_h, out_h;

    typedef struct {
        logic [9:0]  vx;
        logic [8:0]  vy;
        logic        act;
        logic [11:0] bg;
        logic [11:0] ec;
        logic        eh;
    } vec_t;
    vec_t tbl [10];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [11:0] color_of(input int i);
        logic [N*BPC-1:0] c;
        c = COLORS;
        return c[i*BPC +: BPC];
    endfunction

    function automatic int clamp(input int v, input int hi);
        if (v < 0) return 0;
        if (v > hi) return hi;
        return v;
    endfunction

    task automatic model_pixel(output logic [11:0] c, output logic h);
        c = '0;
        h = 1'b0;
        if (active) begin
            c = bg_color;
            for (int i = 0; i < N; i++) begin
                if (!h && int'(x) >= mx[i] && int'(x) <= mx[i] + S - 1 &&
                    int'(y) >= my[i] && int'(y) <= my[i] + S - 1) begin
                    c = color_of(i);
                    h = 1'b1;
                end
            end
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            mx[i] = 100 + 64 * i;
            my[i] = 200;
        end
        msel = 0;
        h1 = '0; h2 = '0; h3 = '0;
        pend_c = '0; out_c = '0; pend_h = 0; out_h = 0;
    endtask

    // one clock: advance the model, then compare every output after the edge
    task automatic tick();
        logic [4:0] cur;
        logic [11:0] c;
        logic hh;
        logic [10*N-1:0] ex;
        logic [9*N-1:0] ey;
        int dx, dy;
        cur = {btn_sel, btn_right, btn_left, btn_down, btn_up};
        if (!reset) begin
            model_reset();
        end else begin
            model_pixel(c, hh);
            out_c = pend_c; out_h = pend_h;
            pend_c = c; pend_h = hh;
            if (screen_end) begin
                dx = (h2[3] ? 2 : 0) - (h2[2] ? 2 : 0);
                dy = (h2[1] ? 2 : 0) - (h2[0] ? 2 : 0);
                mx[msel] = clamp(mx[msel] + dx, 640 - S);
                my[msel] = clamp(my[msel] + dy, 480 - S);
            end
            if (h2[4] && !h3[4]) msel = (msel + 1) % N;
            h3 = h2; h2 = h1; h1 = cur;
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            ex[i*10 +: 10] = 10'(mx[i]);
            ey[i*9 +: 9]   = 9'(my[i]);
        end
        chk("color", color_out, out_c);
        chk("hit", hit, out_h);
        chk("sel", sel_idx, 3'(msel));
        chk("pos_x", pos_x_bus, ex);
        chk("pos_y", pos_y_bus, ey);
    endtask

    task automatic frame(input int len);
        for (int i = 0; i < len - 1; i++) tick();
        screen_end = 1;
        tick();
        screen_end = 0;
    endtask

    task automatic pulse_reset();
        reset = 0;
        tick();
        reset = 1;
    endtask

    task automatic press_sel();
        btn_sel = 1;
        repeat (3) tick();
        btn_sel = 0;
        repeat (3) tick();
    endtask

    task automatic pix(input string name, input int px, input int py, input logic [11:0] ec, input logic eh);
        x = 10'(px); y = 9'(py); active = 1; bg_color = 12'h000;
        tick();
        tick();
        chk({name, "_c"}, color_out, ec);
        chk({name, "_h"}, hit, eh);
    endtask

    initial begin
        tbl[0] = '{10'd100, 9'd200, 1'b1, 12'h000, 12'h1F3, 1'b1};
        tbl[1] = '{10'd149, 9'd249, 1'b1, 12'h000, 12'h1F3, 1'b1};
        tbl[2] = '{10'd150, 9'd200, 1'b1, 12'h123, 12'h123, 1'b0};
        tbl[3] = '{10'd100, 9'd250, 1'b1, 12'h456, 12'h456, 1'b0};
        tbl[4] = '{10'd100, 9'd199, 1'b1, 12'h789, 12'h789, 1'b0};
        tbl[5] = '{10'd164, 9'd200, 1'b1, 12'h000, 12'hA0A, 1'b1};
        tbl[6] = '{10'd213, 9'd220, 1'b1, 12'h000, 12'hA0A, 1'b1};
        tbl[7] = '{10'd341, 9'd249, 1'b1, 12'h000, 12'h777, 1'b1};
        tbl[8] = '{10'd342, 9'd249, 1'b1, 12'hABC, 12'hABC, 1'b0};
        tbl[9] = '{10'd100, 9'd200, 1'b0, 12'h555, 12'h000, 1'b0};
        model_reset();

        reset = 0;
        tick();
        tick();
        reset = 1;
        tick();
        chk("init_x0", pos_x_bus[9:0], 10'd100);
        chk("init_y0", pos_y_bus[8:0], 9'd200);
        chk("init_x3", pos_x_bus[39:30], 10'd292);
        chk("init_sel", sel_idx, 3'd0);
        chk("init_color", color_out, 12'h000);

        for (int i = 0; i < 10; i++) begin
            x = tbl[i].vx; y = tbl[i].vy; active = tbl[i].act; bg_color = tbl[i].bg;
            tick();
            tick();
            chk($sformatf("tbl%0d_color", i), color_out, tbl[i].ec);
            chk($sformatf("tbl%0d_hit", i), hit, tbl[i].eh);
        end
        active = 0;

        btn_right = 1;
        repeat (3) frame(5);
        chk("right3_x0", pos_x_bus[9:0], 10'd106);
        btn_right = 0; btn_up = 1; btn_down = 1;
        repeat (2) frame(5);
        chk("updown_y0", pos_y_bus[8:0], 9'd200);
        btn_up = 0; btn_down = 0;
        btn_right = 1;
        repeat (250) frame(3);
        chk("clamp_right", pos_x_bus[9:0], 10'd590);
        btn_right = 0; btn_left = 1;
        repeat (300) frame(3);
        chk("clamp_left", pos_x_bus[9:0], 10'd0);
        btn_left = 0; btn_up = 1;
        repeat (110) frame(3);
        chk("clamp_up", pos_y_bus[8:0], 9'd0);
        btn_up = 0; btn_down = 1;
        repeat (250) frame(3);
        chk("clamp_down", pos_y_bus[8:0], 9'd430);
        btn_down = 0;

        pulse_reset();
        press_sel();
        chk("sel_one", sel_idx, 3'd1);
        btn_left = 1;
        repeat (32) frame(3);
        btn_left = 0; btn_down = 1;
        repeat (10) frame(3);
        btn_down = 0;
        repeat (3) tick();
        chk("s1_x", pos_x_bus[19:10], 10'd100);
        chk("s1_y", pos_y_bus[17:9], 9'd220);
        pix("overlap", 120, 220, 12'h1F3, 1'b1);
        pix("s1_only", 120, 260, 12'hA0A, 1'b1);
        pix("right_of_s1", 160, 260, 12'h000, 1'b0);
        active = 0;

        pulse_reset();
        btn_left = 1;
        repeat (4) tick();
        btn_sel = 1;
        tick();
        tick();
        screen_end = 1;
        tick();
        screen_end = 0;
        chk("selmove_x0", pos_x_bus[9:0], 10'd98);
        chk("selmove_x1", pos_x_bus[19:10], 10'd164);
        chk("selmove_sel", sel_idx, 3'd1);
        btn_sel = 0;
        repeat (4) tick();
        btn_sel = 1;
        repeat (100) tick();
        chk("hold_sel", sel_idx, 3'd2);
        btn_sel = 0;
        repeat (4) tick();
        press_sel();
        press_sel();
        chk("wrap_sel", sel_idx, 3'd0);
        btn_left = 0;

        btn_right = 1;
        repeat (2) frame(5);
        x = 10'd120; y = 9'd210; active = 1;
        repeat (3) tick();
        reset = 0;
        tick();
        chk("rst_x0", pos_x_bus[9:0], 10'd100);
        chk("rst_sel", sel_idx, 3'd0);
        chk("rst_color", color_out, 12'h000);
        chk("rst_hit", hit, 1'b0);
        reset = 1;
        btn_right = 0;

        for (int f = 0; f < 200; f++) begin
            int len;
            btn_up    = ($urandom_range(0, 3) == 0);
            btn_down  = ($urandom_range(0, 3) == 0);
            btn_left  = ($urandom_range(0, 2) == 0);
            btn_right = ($urandom_range(0, 2) == 0);
            btn_sel   = ($urandom_range(0, 3) == 0);
            len = $urandom_range(3, 8);
            for (int t = 0; t < len; t++) begin
                x = 10'($urandom_range(0, 699));
                y = 9'($urandom_range(0, 511));
                active = ($urandom_range(0, 4) != 0);
                bg_color = 12'($urandom);
                screen_end = (t == len - 1);
                reset = !($urandom_range(0, 299) == 0);
                tick();
            end
            screen_end = 0;
            reset = 1;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
